// File: rtl/eth_rx_mac_filter_if.sv
// Byte-wide AXI-Stream link used on both sides of the RX MAC filter.
interface eth_rx_mac_filter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_mac_filter.sv
// RX destination-MAC filter: holds the 6-byte dest address, decides pass/drop,
// replays the header and then cuts through the rest of an accepted frame.
module eth_rx_mac_filter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clock125,
  input  logic                     reset,
  eth_rx_mac_filter_if.slave       s_axis,
  eth_rx_mac_filter_if.master      m_axis,
  input  logic [47:0]              mac_addr,
  input  logic                     promiscuous,
  input  logic                     accept_broadcast,
  input  logic                     accept_multicast,
  output logic [CNT_WIDTH-1:0]     frames_passed,
  output logic [CNT_WIDTH-1:0]     frames_dropped,
  output logic [CNT_WIDTH-1:0]     frames_runt
);

  typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [5:0][7:0] hdr;
  logic [47:0]     dest;
  logic            accept;
  logic            hdr_we, inc_pass, inc_drop, inc_runt;
  logic            s_rdy, m_vld;
  logic [7:0]      m_data;
  logic            m_last, m_user;
  logic            s_hs;

  // Byte 5 is still on the bus when the decision is made, so take it live.
  assign dest = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], s_axis.tdata};

  always_comb begin
    if (promiscuous)   accept = 1'b1;
    else if (&dest)    accept = accept_broadcast;
    else if (dest[40]) accept = accept_multicast;
    else               accept = (dest == mac_addr);
  end

  assign s_hs = s_axis.tvalid && s_rdy;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hdr_we    = 1'b0;
    inc_pass  = 1'b0;
    inc_drop  = 1'b0;
    inc_runt  = 1'b0;
    s_rdy     = 1'b0;
    m_vld     = 1'b0;
    m_data    = hdr[idx];
    m_last    = 1'b0;
    m_user    = 1'b0;
    unique case (state)
      HDR: begin
        s_rdy = 1'b1;
        if (s_hs) begin
          hdr_we = 1'b1;
          if (s_axis.tlast) begin
            inc_runt = 1'b1;
            idx_nxt  = '0;
          end else if (idx == 3'd5) begin
            idx_nxt   = '0;
            state_nxt = accept ? REPLAY : DROP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      REPLAY: begin
        m_vld = 1'b1;
        if (m_axis.tready) begin
          if (idx == 3'd5) begin
            idx_nxt   = '0;
            state_nxt = PASS;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      PASS: begin
        s_rdy  = m_axis.tready;
        m_vld  = s_axis.tvalid;
        m_data = s_axis.tdata;
        m_last = s_axis.tlast;
        m_user = s_axis.tuser;
        if (s_hs && s_axis.tlast) begin
          inc_pass  = 1'b1;
          state_nxt = HDR;
        end
      end
      DROP: begin
        s_rdy = 1'b1;
        if (s_hs && s_axis.tlast) begin
          inc_drop  = 1'b1;
          state_nxt = HDR;
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  // Both handshakes are held off while reset is high, whatever the state register holds.
  assign s_axis.tready = s_rdy && !reset;
  assign m_axis.tvalid = m_vld && !reset;
  assign m_axis.tdata  = m_data;
  assign m_axis.tlast  = m_last;
  assign m_axis.tuser  = m_user;

  always_ff @(posedge clock125) begin
    if (reset) begin
      state          <= HDR;
      idx            <= '0;
      frames_passed  <= '0;
      frames_dropped <= '0;
      frames_runt    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (hdr_we) hdr[idx] <= s_axis.tdata;
      if (inc_pass && !(&frames_passed))   frames_passed  <= frames_passed  + CNT_WIDTH'(1);
      if (inc_drop && !(&frames_dropped))  frames_dropped <= frames_dropped + CNT_WIDTH'(1);
      if (inc_runt && !(&frames_runt))     frames_runt    <= frames_runt    + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed bench for eth_rx_mac_filter; narrow counters so saturation is reachable.
module tb_eth_rx_mac_filter;
  localparam int CW = 3;

  logic clock125 = 1'b0;
  logic reset;
  logic [47:0] mac_addr;
  logic promiscuous, accept_broadcast, accept_multicast;
  logic [CW-1:0] frames_passed, frames_dropped, frames_runt;

  eth_rx_mac_filter_if s_if ();
  eth_rx_mac_filter_if m_if ();

  eth_rx_mac_filter #(.CNT_WIDTH(CW)) dut (
    .clock125         (clock125),
    .reset            (reset),
    .s_axis           (s_if.slave),
    .m_axis           (m_if.master),
    .mac_addr         (mac_addr),
    .promiscuous      (promiscuous),
    .accept_broadcast (accept_broadcast),
    .accept_multicast (accept_multicast),
    .frames_passed    (frames_passed),
    .frames_dropped   (frames_dropped),
    .frames_runt      (frames_runt)
  );

  always #5 clock125 = ~clock125;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int   n_last;
  int   last_pos;
  logic last_user;
  bit   bp_en = 1'b0;

  // Output monitor; optional random downstream backpressure.
  always begin
    @(negedge clock125);
    if (bp_en) m_if.tready = 1'($urandom_range(0, 1));
    #1;
    if (m_if.tvalid && m_if.tready) begin
      rx_q.push_back(m_if.tdata);
      if (m_if.tlast) begin
        n_last++;
        last_pos  = rx_q.size();
        last_user = m_if.tuser;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_frame(input logic [47:0] dst, input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++)
      tx_q.push_back(i < 6 ? dst[47-8*i -: 8] : 8'(i * 7 + 3));
  endtask

  task automatic clr_rx();
    rx_q.delete();
    n_last    = 0;
    last_pos  = 0;
    last_user = 1'b0;
  endtask

  task automatic send_frame(input int n_stop, input bit bad);
    int i = 0;
    int budget = 0;
    int goal = (n_stop < tx_q.size()) ? n_stop : tx_q.size();
    while (i < goal && budget < 1000) begin
      @(negedge clock125);
      s_if.tvalid = 1'b1;
      s_if.tdata  = tx_q[i];
      s_if.tlast  = (i == tx_q.size() - 1);
      s_if.tuser  = bad && (i == tx_q.size() - 1);
      #1;
      if (s_if.tready) i++;
      else budget++;
    end
    chk("tx_progress", 64'(i), 64'(goal));
    @(negedge clock125);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock125);
    #1;
  endtask

  // Compare collected output with the whole transmitted frame.
  task automatic check_rx(input string tag, input bit exp_user);
    int mism = 0;
    chk({tag, "_len"}, 64'(rx_q.size()), 64'(tx_q.size()));
    for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== tx_q[i]) mism++;
    chk({tag, "_data"}, 64'(mism), 64'd0);
    chk({tag, "_nlast"}, 64'(n_last), 64'd1);
    chk({tag, "_lastpos"}, 64'(last_pos), 64'(tx_q.size()));
    chk({tag, "_tuser"}, 64'(last_user), 64'(exp_user));
  endtask

  initial begin
    reset            = 1'b1;
    s_if.tvalid      = 1'b0;
    s_if.tdata       = '0;
    s_if.tlast       = 1'b0;
    s_if.tuser       = 1'b0;
    m_if.tready      = 1'b1;
    mac_addr         = 48'h001122334455;
    promiscuous      = 1'b0;
    accept_broadcast = 1'b0;
    accept_multicast = 1'b0;
    clr_rx();

    idle(3);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_passed",   64'(frames_passed),  64'd0);
    chk("rst_dropped",  64'(frames_dropped), 64'd0);
    chk("rst_runt",     64'(frames_runt),    64'd0);
    reset = 1'b0;
    #1;
    chk("hdr_s_tready", 64'(s_if.tready), 64'd1);

    // Unicast match, 64 bytes
    clr_rx();
    make_frame(48'h001122334455, 64);
    send_frame(1000, 1'b0);
    idle(2);
    check_rx("ucast", 1'b0);
    chk("ucast_passed", 64'(frames_passed), 64'd1);

    // Unicast mismatch in the last dest byte
    clr_rx();
    make_frame(48'h001122334456, 64);
    send_frame(1000, 1'b0);
    idle(2);
    chk("mism_rxlen",  64'(rx_q.size()), 64'd0);
    chk("mism_dropped", 64'(frames_dropped), 64'd1);

    // Same frame under promiscuous mode
    clr_rx();
    promiscuous = 1'b1;
    send_frame(1000, 1'b0);
    idle(2);
    promiscuous = 1'b0;
    check_rx("promisc", 1'b0);
    chk("promisc_passed", 64'(frames_passed), 64'd2);

    // Broadcast rejected even though multicast is enabled
    clr_rx();
    accept_multicast = 1'b1;
    make_frame(48'hFFFFFFFFFFFF, 64);
    send_frame(1000, 1'b0);
    idle(2);
    chk("bcast_rxlen",   64'(rx_q.size()), 64'd0);
    chk("bcast_dropped", 64'(frames_dropped), 64'd2);

    // Multicast accepted
    clr_rx();
    make_frame(48'h01005E000001, 64);
    send_frame(1000, 1'b0);
    idle(2);
    check_rx("mcast", 1'b0);
    chk("mcast_passed", 64'(frames_passed), 64'd3);
    accept_multicast = 1'b0;

    // Runts: 5 and 6 bytes, both matching unicast
    clr_rx();
    make_frame(48'h001122334455, 5);
    send_frame(1000, 1'b0);
    make_frame(48'h001122334455, 6);
    send_frame(1000, 1'b0);
    idle(2);
    chk("runt_rxlen",  64'(rx_q.size()), 64'd0);
    chk("runt_count",  64'(frames_runt), 64'd2);
    chk("runt_passed", 64'(frames_passed), 64'd3);

    // Matching frame right after the runts
    clr_rx();
    make_frame(48'h001122334455, 60);
    send_frame(1000, 1'b0);
    idle(2);
    check_rx("post_runt", 1'b0);
    chk("post_runt_passed", 64'(frames_passed), 64'd4);

    // Random downstream backpressure, bad-frame flag on the last byte
    clr_rx();
    bp_en = 1'b1;
    make_frame(48'h001122334455, 40);
    send_frame(1000, 1'b1);
    idle(4);
    bp_en = 1'b0;
    m_if.tready = 1'b1;
    check_rx("bp", 1'b1);
    chk("bp_passed", 64'(frames_passed), 64'd5);

    // Drive frames_dropped to all-ones, then one more drop
    make_frame(48'h001122334499, 7);
    repeat (5) send_frame(1000, 1'b0);
    idle(2);
    chk("sat_reach", 64'(frames_dropped), 64'd7);
    send_frame(1000, 1'b0);
    idle(2);
    chk("sat_hold", 64'(frames_dropped), 64'd7);

    // Reset while cutting through a frame
    clr_rx();
    make_frame(48'h001122334455, 30);
    send_frame(12, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_if.tready), 64'd0);
    idle(1);
    chk("midrst_passed",  64'(frames_passed),  64'd0);
    chk("midrst_dropped", 64'(frames_dropped), 64'd0);
    chk("midrst_runt",    64'(frames_runt),    64'd0);
    reset = 1'b0;

    // Filtering still correct after the reset
    idle(1);
    clr_rx();
    make_frame(48'h001122334455, 20);
    send_frame(1000, 1'b0);
    idle(2);
    check_rx("after_rst", 1'b0);
    chk("after_rst_passed", 64'(frames_passed), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_mac_filter.md
Name: eth_rx_mac_filter

Overview:
- Sits directly downstream of the 1G RGMII MAC wrapper's RX AXI-Stream output (8-bit, 125 MHz domain), ahead of the host DMA/FIFO.
- Buffers the 6-byte destination MAC of each frame and decides whether to forward or discard the whole frame.
- Decision inputs: unicast match, broadcast, multicast, promiscuous.
- Keeps saturating pass/drop/runt counters for software.

Parameters:
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clock125  input  1  125 MHz clock; all logic on this clock.
- reset  input  1  synchronous, active-high reset.
- s_axis_tdata  input  8  frame byte from MAC.
- s_axis_tvalid  input  1  upstream valid.
- s_axis_tready  output  1  upstream ready.
- s_axis_tlast  input  1  last byte of frame.
- s_axis_tuser  input  1  bad-frame flag, meaningful only with tlast.
- m_axis_tdata  output  8  forwarded byte.
- m_axis_tvalid  output  1  downstream valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  last byte.
- m_axis_tuser  output  1  bad-frame flag, forwarded with tlast.
- mac_addr  input  48  station address; first wire byte = mac_addr[47:40].
- promiscuous  input  1  accept every frame of 7 or more bytes.
- accept_broadcast  input  1  accept dest FF:FF:FF:FF:FF:FF.
- accept_multicast  input  1  accept dest with byte0 bit0=1 (non-broadcast).
- frames_passed  output  CNT_WIDTH  frames fully forwarded.
- frames_dropped  output  CNT_WIDTH  frames rejected by filter.
- frames_runt  output  CNT_WIDTH  frames ending at or before byte 6.

Behaviour:
- Reset, synchronous and active-high: state=HDR, byte index=0, all counters=0, m_axis_tvalid=0, s_axis_tready=0 during reset. The upstream MAC shares this reset, so no frame is in flight at release. Reset mid-frame abandons the frame without counting it.
- HDR state:
  - s_axis_tready=1, m_axis_tvalid=0.
  - Each accepted byte is stored in hdr[idx] and idx increments.
  - tlast accepted with idx<=5 (frame of 6 bytes or fewer): discard, frames_runt+1, idx=0, stay HDR.
  - 6th byte accepted without tlast: evaluate the filter combinationally on hdr[0..4] plus the incoming byte, using config inputs sampled on this cycle, then go to REPLAY (accept) or DROP (reject). idx=0.
- Filter rule, priority order:
  - promiscuous=1 -> accept.
  - dest==FF..FF -> accept iff accept_broadcast.
  - dest byte0[0]=1 -> accept iff accept_multicast.
  - dest==mac_addr -> accept.
  - otherwise reject.
- REPLAY state:
  - s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=hdr[idx], tlast=0, tuser=0.
  - idx advances on m_axis_tready.
  - After hdr[5] is handshaken: idx=0, go to PASS.
  - Data must stay stable while tready=0.
- PASS state:
  - Combinational pass-through: m_tdata/tvalid/tlast/tuser = s_* and s_axis_tready = m_axis_tready. No added latency, no bubbles.
  - On a tlast handshake: frames_passed+1, go to HDR.
- DROP state:
  - s_axis_tready=1, m_axis_tvalid=0; bytes are discarded.
  - On tlast accepted: frames_dropped+1, go to HDR. tuser is ignored.
- Header latency: first output byte is presented the cycle after the 6th input byte is accepted. Minimum 6 replay cycles before upstream is re-readied.
- Counters saturate at all-ones and never wrap. They are updated in the cycle after the triggering handshake.
- Bad frames (tuser=1 on tlast) that pass the filter are forwarded with tuser=1 and counted in frames_passed.
- Config changes mid-frame do not affect the current frame once it has been decided.
- Back-to-back frames: HDR accepts the next frame's byte 0 in the cycle after the previous tlast handshake.

Test Plan:
- Unicast match: mac_addr=0x001122334455, 64-byte frame with dest 00:11:22:33:44:55, m_tready=1 -> 64 bytes out in identical order, tlast on byte 64, frames_passed=1.
- Mismatch: same config, dest 00:11:22:33:44:56 -> no m_tvalid, all 64 bytes consumed, frames_dropped=1. Repeat with promiscuous=1 -> passed.
- Broadcast/multicast: dest FF..FF with accept_broadcast=0 and accept_multicast=1 -> dropped. Dest 01:00:5E:00:00:01 with accept_multicast=1 -> passed.
- Runt: 5-byte frame with tlast on byte 5, then a 6-byte frame -> no output, frames_runt=2. A following 60-byte matching frame passes intact.
- Backpressure: m_tready toggles randomly 50% during REPLAY and PASS -> output byte sequence equals input, no duplication or loss. tuser=1 on the final byte is forwarded.
- Saturation/reset: force a counter to all-ones and drop one more frame -> value unchanged. Assert reset mid-PASS -> outputs idle and counters 0 the next cycle. The next frame filters correctly.
